stopwatch_display: RTL and testbench

- Drives a 4-digit multiplexed, active-low, common-anode 7-segment display for a MM:SS stopwatch.
- Internally generates a scan-refresh tick and a 5 Hz-class blink phase from the system clock.
- Scans the four BCD digit inputs and blanks the selected field while in adjust mode.
- Mirrors adjust status onto LEDs.
- Sits between the stopwatch counter and the board pins.

---
 rtl/stopwatch_display_pkg.sv | 46 ++++
 rtl/stopwatch_display_seg7_decoder.sv | 27 ++
 rtl/stopwatch_display.sv | 120 ++++++++++++
 tb/tb_stopwatch_display.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_display_pkg.sv
// rtl/stopwatch_display_pkg.sv - segment, anode and field-select constants for the stopwatch display
package stopwatch_display_pkg;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Active-low, one-hot-low anode patterns per scan slot
  localparam logic [3:0] AN_SEC_R = 4'b1110;
  localparam logic [3:0] AN_SEC_L = 4'b1101;
  localparam logic [3:0] AN_MIN_R = 4'b1011;
  localparam logic [3:0] AN_MIN_L = 4'b0111;
  localparam logic [3:0] AN_OFF   = 4'b1111;

  // Field codes carried on adj_sel; any other code selects nothing
  localparam logic [2:0] SEL_MIN = 3'd0;
  localparam logic [2:0] SEL_SEC = 3'd1;

  // Scan slot order, rightmost digit first
  typedef enum logic [1:0] {
    SLOT_SEC_R = 2'd0,
    SLOT_SEC_L = 2'd1,
    SLOT_MIN_R = 2'd2,
    SLOT_MIN_L = 2'd3
  } slot_t;

  // Anode pattern for a scan slot
  function automatic logic [3:0] anode_for(input slot_t slot);
    case (slot)
      SLOT_SEC_R: anode_for = AN_SEC_R;
      SLOT_SEC_L: anode_for = AN_SEC_L;
      SLOT_MIN_R: anode_for = AN_MIN_R;
      default:    anode_for = AN_MIN_L;
    endcase
  endfunction

endpackage

// File: rtl/stopwatch_display_seg7_decoder.sv
// rtl/stopwatch_display_seg7_decoder.sv - BCD digit to active-low 7-segment pattern, blank above 9
module seg7_decoder
  import stopwatch_display_pkg::*;
(
  input  logic [4:0] digit,
  output logic [6:0] seg
);

  // Table lookup; anything outside 0..9 goes dark
  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      5'd0: seg = SEG_0;
      5'd1: seg = SEG_1;
      5'd2: seg = SEG_2;
      5'd3: seg = SEG_3;
      5'd4: seg = SEG_4;
      5'd5: seg = SEG_5;
      5'd6: seg = SEG_6;
      5'd7: seg = SEG_7;
      5'd8: seg = SEG_8;
      5'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/stopwatch_display.sv
// rtl/stopwatch_display.sv - MM:SS multiplexed 7-seg driver with adjust blink; option LEADING_ZERO_BLANK_EN
module stopwatch_display
  import stopwatch_display_pkg::*;
#(
  parameter int REFRESH_W = 18,
  parameter int BLINK_DIV = 20000000
) (
  input  logic       clk,
  input  logic       btn_reset,
  input  logic       adj,
  input  logic [2:0] adj_sel,
  input  logic [4:0] min_l,
  input  logic [4:0] min_r,
  input  logic [4:0] sec_l,
  input  logic [4:0] sec_r,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic [6:0] Led
);

  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  logic [REFRESH_W-1:0] scan_cnt;
  slot_t                scan_idx;
  logic [BLINK_W-1:0]   blink_cnt;
  logic                 blink_hidden;

  logic [4:0] digit;
  logic [3:0] an_slot;
  logic       in_field;
  logic       adj_blank;
  logic [6:0] seg_dec;
  logic [6:0] seg_next;
  logic [3:0] an_next;

  seg7_decoder u_decoder (
    .digit (digit),
    .seg   (seg_dec)
  );

  // Free-running refresh counter; the scan slot steps on its wrap
  always_ff @(posedge clk) begin
    if (btn_reset) begin
      scan_cnt <= '0;
      scan_idx <= SLOT_SEC_R;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
      if (&scan_cnt) begin
        scan_idx <= slot_t'(scan_idx + 2'd1);
      end
    end
  end

  // Blink phase generator; runs whether or not adjust is active
  always_ff @(posedge clk) begin
    if (btn_reset) begin
      blink_cnt    <= '0;
      blink_hidden <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt    <= '0;
      blink_hidden <= ~blink_hidden;
    end else begin
      blink_cnt    <= blink_cnt + 1'b1;
    end
  end

  // Select the digit for the current slot and decide whether it is adjust-blanked
  always_comb begin
    digit    = sec_r;
    in_field = 1'b0;
    case (scan_idx)
      SLOT_SEC_R: begin
        digit    = sec_r;
        in_field = (adj_sel == SEL_SEC);
      end
      SLOT_SEC_L: begin
        digit    = sec_l;
        in_field = (adj_sel == SEL_SEC);
      end
      SLOT_MIN_R: begin
        digit    = min_r;
        in_field = (adj_sel == SEL_MIN);
      end
      default: begin
        digit    = min_l;
        in_field = (adj_sel == SEL_MIN);
      end
    endcase
    an_slot   = anode_for(scan_idx);
    adj_blank = adj && blink_hidden && in_field;
  end

  // Next-state values for the pin registers
  always_comb begin
    seg_next = seg_dec;
    an_next  = adj_blank ? AN_OFF : an_slot;
`ifdef LEADING_ZERO_BLANK_EN
    if ((scan_idx == SLOT_MIN_L) && (min_l == 5'd0)) begin
      seg_next = SEG_BLANK;
    end
`else
    seg_next = seg_dec;
`endif
  end

  // Registered board outputs
  always_ff @(posedge clk) begin
    if (btn_reset) begin
      seg <= SEG_BLANK;
      an  <= AN_OFF;
      Led <= 7'b0000000;
    end else begin
      seg <= seg_next;
      an  <= an_next;
      Led <= {adj, 3'b000, adj_sel};
    end
  end

endmodule

// File: tb/tb_stopwatch_display.sv
// tb/tb_stopwatch_display.sv - scoreboard bench for stopwatch_display with REFRESH_W=4, BLINK_DIV=8
module tb_stopwatch_display;

  logic       clk = 1'b0;
  logic       btn_reset = 1'b1;
  logic       adj = 1'b0;
  logic [2:0] adj_sel = 3'd0;
  logic [4:0] min_l = 5'd0;
  logic [4:0] min_r = 5'd0;
  logic [4:0] sec_l = 5'd0;
  logic [4:0] sec_r = 5'd0;
  logic [6:0] seg;
  logic [3:0] an;
  logic [6:0] Led;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Cycles since the last reset edge, as seen by the reference model
  int n_model = 0;

  // Expected {an, seg, Led}
  logic [17:0] sb_q[$];
  logic [17:0] exp_v;
  logic [17:0] got_v;

  stopwatch_display #(.REFRESH_W(4), .BLINK_DIV(8)) dut (
    .clk       (clk),
    .btn_reset (btn_reset),
    .adj       (adj),
    .adj_sel   (adj_sel),
    .min_l     (min_l),
    .min_r     (min_r),
    .sec_l     (sec_l),
    .sec_r     (sec_r),
    .seg       (seg),
    .an        (an),
    .Led       (Led)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] ref_decode(input logic [4:0] d);
    logic [6:0] tbl [10];
    tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    if (d <= 5'd9) return tbl[d];
    return 7'b1111111;
  endfunction

  // Expected outputs produced by the next rising edge, from current inputs and cycle count
  function automatic logic [17:0] ref_expect(input int n);
    int         slot;
    bit         hidden;
    logic [4:0] d;
    logic [3:0] a;
    logic [6:0] s;
    bit         field;
    if (btn_reset) return {4'b1111, 7'b1111111, 7'b0000000};
    slot   = (n / 16) % 4;
    hidden = ((n / 8) % 2) == 1;
    case (slot)
      0: begin d = sec_r; a = 4'b1110; field = (adj_sel == 3'd1); end
      1: begin d = sec_l; a = 4'b1101; field = (adj_sel == 3'd1); end
      2: begin d = min_r; a = 4'b1011; field = (adj_sel == 3'd0); end
      default: begin d = min_l; a = 4'b0111; field = (adj_sel == 3'd0); end
    endcase
    s = ref_decode(d);
`ifdef LEADING_ZERO_BLANK_EN
    if (slot == 3 && min_l == 5'd0) s = 7'b1111111;
`endif
    if (adj && hidden && field) a = 4'b1111;
    return {a, s, adj, 3'b000, adj_sel};
  endfunction

  // Push the expectation for the coming edge, take the edge, advance the model
  task automatic drive_edge();
    sb_q.push_back(ref_expect(n_model));
    @(posedge clk);
    #1;
    n_model = btn_reset ? 0 : n_model + 1;
  endtask

  task automatic test_reset();
    btn_reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_edge();
      total_cnt++;
      if (sb_q.size() == 0) $display("FAIL reset: scoreboard empty");
      else begin
        exp_v = sb_q.pop_front();
        got_v = {an, seg, Led};
        if (got_v !== exp_v) $display("FAIL reset: an/seg/Led got %b want %b", got_v, exp_v);
        else pass_cnt++;
      end
    end
    total_cnt++;
    if ({seg, an, Led} !== {7'b1111111, 4'b1111, 7'b0}) $display("FAIL reset_const: got seg=%b an=%b Led=%b want 1111111/1111/0000000", seg, an, Led);
    else pass_cnt++;
  endtask

  task automatic test_scan();
    btn_reset = 1'b0;
    adj = 1'b0; adj_sel = 3'd0;
    min_l = 5'd5; min_r = 5'd6; sec_l = 5'd7; sec_r = 5'd8;
    for (int i = 0; i < 96; i++) begin
      drive_edge();
      total_cnt++;
      if (sb_q.size() == 0) $display("FAIL scan: scoreboard empty");
      else begin
        exp_v = sb_q.pop_front();
        got_v = {an, seg, Led};
        if (got_v !== exp_v) $display("FAIL scan[%0d]: an/seg/Led got %b want %b", i, got_v, exp_v);
        else pass_cnt++;
      end
      // After the first wrap the second slot (sec_l = 7) is on
      if (i == 16) begin
        total_cnt++;
        if ({an, seg} !== {4'b1101, 7'b1111000}) $display("FAIL scan_slot1: got an=%b seg=%b want 1101/1111000", an, seg);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_invalid_digit();
    btn_reset = 1'b1;
    drive_edge();
    void'(sb_q.pop_front());
    btn_reset = 1'b0;
    sec_r = 5'd12;
    for (int i = 0; i < 20; i++) begin
      drive_edge();
      total_cnt++;
      if (sb_q.size() == 0) $display("FAIL invalid_digit: scoreboard empty");
      else begin
        exp_v = sb_q.pop_front();
        got_v = {an, seg, Led};
        if (got_v !== exp_v) $display("FAIL invalid_digit[%0d]: an/seg/Led got %b want %b", i, got_v, exp_v);
        else pass_cnt++;
      end
      if (i == 3) begin
        total_cnt++;
        if ({an, seg} !== {4'b1110, 7'b1111111}) $display("FAIL invalid_slot0: got an=%b seg=%b want 1110/1111111", an, seg);
        else pass_cnt++;
      end
    end
    sec_r = 5'd8;
  endtask

  task automatic test_adjust_blink();
    adj = 1'b1;
    for (int f = 0; f < 2; f++) begin
      adj_sel = (f == 0) ? 3'd1 : 3'd0;
      for (int i = 0; i < 64; i++) begin
        drive_edge();
        total_cnt++;
        if (sb_q.size() == 0) $display("FAIL adjust_blink: scoreboard empty");
        else begin
          exp_v = sb_q.pop_front();
          got_v = {an, seg, Led};
          if (got_v !== exp_v) $display("FAIL adjust_blink[sel=%0d,%0d]: an/seg/Led got %b want %b", adj_sel, i, got_v, exp_v);
          else pass_cnt++;
        end
      end
    end
    total_cnt++;
    if (Led !== 7'b1000000) $display("FAIL adjust_led: got %b want 1000000", Led);
    else pass_cnt++;
  endtask

  task automatic test_sel_none();
    adj = 1'b1; adj_sel = 3'd5;
    for (int i = 0; i < 40; i++) begin
      if (i == 32) adj = 1'b0;
      drive_edge();
      total_cnt++;
      if (sb_q.size() == 0) $display("FAIL sel_none: scoreboard empty");
      else begin
        exp_v = sb_q.pop_front();
        got_v = {an, seg, Led};
        if (got_v !== exp_v) $display("FAIL sel_none[%0d]: an/seg/Led got %b want %b", i, got_v, exp_v);
        else pass_cnt++;
      end
      if (i == 31 || i == 32) begin
        total_cnt++;
        if (Led !== ((i == 31) ? 7'b1000101 : 7'b0000101)) $display("FAIL sel_none_led[%0d]: got %b want %b", i, Led, (i == 31) ? 7'b1000101 : 7'b0000101);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_reset_mid_blink();
    btn_reset = 1'b1;
    drive_edge();
    void'(sb_q.pop_front());
    btn_reset = 1'b0;
    adj = 1'b1; adj_sel = 3'd1;
    for (int i = 0; i < 12; i++) begin
      drive_edge();
      void'(sb_q.pop_front());
    end
    total_cnt++;
    if (an !== 4'b1111) $display("FAIL mid_blink_hidden: got an=%b want 1111", an);
    else pass_cnt++;
    btn_reset = 1'b1;
    drive_edge();
    void'(sb_q.pop_front());
    btn_reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      drive_edge();
      total_cnt++;
      if (sb_q.size() == 0) $display("FAIL reset_mid_blink: scoreboard empty");
      else begin
        exp_v = sb_q.pop_front();
        got_v = {an, seg, Led};
        if (got_v !== exp_v) $display("FAIL reset_mid_blink[%0d]: an/seg/Led got %b want %b", i, got_v, exp_v);
        else pass_cnt++;
      end
      if (i == 0) begin
        total_cnt++;
        if (an !== 4'b1110) $display("FAIL restart_slot0: got an=%b want 1110", an);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_digit_sweep();
    adj = 1'b0; adj_sel = 3'd0;
    for (int i = 0; i < 256; i++) begin
      min_l = 5'($urandom_range(0, 31));
      min_r = 5'($urandom_range(0, 31));
      sec_l = 5'($urandom_range(0, 31));
      sec_r = 5'($urandom_range(0, 31));
      if (i % 3 == 0) min_l = 5'd0;
      if (i % 17 == 0) begin adj = ~adj; adj_sel = 3'($urandom_range(0, 2)); end
      drive_edge();
      total_cnt++;
      if (sb_q.size() == 0) $display("FAIL digit_sweep: scoreboard empty");
      else begin
        exp_v = sb_q.pop_front();
        got_v = {an, seg, Led};
        if (got_v !== exp_v) $display("FAIL digit_sweep[%0d]: an/seg/Led got %b want %b", i, got_v, exp_v);
        else pass_cnt++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_invalid_digit();
    test_adjust_blink();
    test_sel_none();
    test_reset_mid_blink();
    test_digit_sweep();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
